// File: rtl/registered_nx1_mux.sv
// Registered N-to-1 mux with valid/ready per channel, fixed-select or round-robin grant.
// Optional even-parity output Out_Parity when MUX_PARITY_EN is defined.
module registered_nx1_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [CHANNELS*WIDTH-1:0] In_Data,
  input  logic [CHANNELS-1:0]       In_Valid,
  output logic [CHANNELS-1:0]       In_Ready,
  input  logic [SEL_W-1:0]          Select,
  input  logic                      Mode,
  output logic [WIDTH-1:0]          Out,
  output logic                      Out_Valid,
  input  logic                      Out_Ready,
`ifdef MUX_PARITY_EN
  output logic                      Out_Parity,
`endif
  output logic [SEL_W-1:0]          Out_Channel
);

  localparam int unsigned CH = CHANNELS;

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_vld_q, out_vld_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             load;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] sel_data;

  assign load = !out_vld_q || Out_Ready;

  // Round-robin: offset i from ptr wraps onto channel k when ptr+i is k or k+CH.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    if (!Mode) begin
      for (int unsigned k = 0; k < CH; k++) begin
        if (32'(Select) == k && In_Valid[k]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(k);
        end
      end
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        for (int unsigned k = 0; k < CH; k++) begin
          if (!grant_vld && In_Valid[k] &&
              ((32'(ptr_q) + i == k) || (32'(ptr_q) + i == k + CH))) begin
            grant_vld = 1'b1;
            grant     = SEL_W'(k);
          end
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    In_Ready = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (grant == SEL_W'(k)) begin
        sel_data    = In_Data[k*WIDTH +: WIDTH];
        In_Ready[k] = load && grant_vld;
      end
    end
  end

  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    out_ch_d  = out_ch_q;
    ptr_d     = ptr_q;
    if (load) begin
      out_vld_d = grant_vld;
      if (grant_vld) begin
        out_d    = sel_data;
        out_ch_d = grant;
        if (Mode) begin
          ptr_d = (32'(grant) == CH - 1) ? '0 : grant + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      out_ch_q  <= '0;
      ptr_q     <= '0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      out_ch_q  <= out_ch_d;
      ptr_q     <= ptr_d;
    end
  end

`ifdef MUX_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (load && grant_vld) begin
      par_d = ^sel_data;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign Out_Parity = par_q;
`endif

  assign Out         = out_q;
  assign Out_Valid   = out_vld_q;
  assign Out_Channel = out_ch_q;

endmodule
